// File: rtl/si5340_reg_write_sequencer_if.sv
// Word-in / byte-command-out bus between the config serializer, the Si5340
// write sequencer and the i2c_master_byte controller.
interface si5340_reg_write_sequencer_if;
  logic [23:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic        start_o;
  logic        stop_o;
  logic        write_o;
  logic        read_o;
  logic        ack_in_o;
  logic [7:0]  din_o;
  logic        cmd_ack_i;
  logic        ack_out_i;
  logic        word_done_o;
  logic        busy_o;
  logic        error_o;
  logic [3:0]  retry_cnt_o;

  modport master (
    input  word_i, word_valid_i, cmd_ack_i, ack_out_i,
    output word_ready_o, start_o, stop_o, write_o, read_o, ack_in_o, din_o,
           word_done_o, busy_o, error_o, retry_cnt_o
  );

  modport slave (
    output word_i, word_valid_i, cmd_ack_i, ack_out_i,
    input  word_ready_o, start_o, stop_o, write_o, read_o, ack_in_o, din_o,
           word_done_o, busy_o, error_o, retry_cnt_o
  );
endinterface

// File: rtl/si5340_reg_write_sequencer.sv
// Turns {reg_addr, data} words into Si5340 page-select and register-write
// I2C byte commands, with page caching, NACK retry and a sticky error.
module si5340_reg_write_sequencer #(
  parameter logic [6:0] DEV_ADDR  = 7'h74,
  parameter logic [7:0] PAGE_REG  = 8'h01,
  parameter int unsigned RETRY_MAX = 3
) (
  input logic clk_i,
  input logic arst_i,
  si5340_reg_write_sequencer_if.master bus
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PG_DEV = 4'd1;
  localparam logic [3:0] S_PG_REG = 4'd2;
  localparam logic [3:0] S_PG_DAT = 4'd3;
  localparam logic [3:0] S_WR_DEV = 4'd4;
  localparam logic [3:0] S_WR_REG = 4'd5;
  localparam logic [3:0] S_WR_DAT = 4'd6;
  localparam logic [3:0] S_ABORT  = 4'd7;
  localparam logic [3:0] S_RETRY  = 4'd8;
  localparam logic [3:0] S_ERROR  = 4'd9;

  localparam logic [7:0] DEV_BYTE = {DEV_ADDR, 1'b0};

  logic [3:0]  state_reg;
  logic [23:0] word_reg;
  logic [7:0]  page_reg;
  logic        page_valid_reg;
  logic        pending_reg;
  logic        start_reg, stop_reg, write_reg;
  logic [7:0]  din_reg;
  logic        done_reg;
  logic        error_reg;
  logic [3:0]  retry_reg;

  logic        cmd_start, cmd_stop, cmd_write;
  logic [7:0]  cmd_din;
  logic [3:0]  ack_state;
  logic [3:0]  retry_inc;
  logic        page_hit;
  logic        nack;

  assign nack      = bus.ack_out_i;
  assign page_hit  = page_valid_reg && (page_reg == bus.word_i[23:16]);
  assign retry_inc = (retry_reg == 4'hF) ? 4'hF : retry_reg + 4'd1;

  // Command presented by each issuing state, and where its completion leads.
  always_comb begin
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_write = 1'b0;
    cmd_din   = 8'h00;
    ack_state = state_reg;
    case (state_reg)
      S_PG_DEV: begin
        cmd_start = 1'b1; cmd_write = 1'b1; cmd_din = DEV_BYTE;
        ack_state = nack ? S_ABORT : S_PG_REG;
      end
      S_PG_REG: begin
        cmd_write = 1'b1; cmd_din = PAGE_REG;
        ack_state = nack ? S_ABORT : S_PG_DAT;
      end
      S_PG_DAT: begin
        cmd_write = 1'b1; cmd_stop = 1'b1; cmd_din = word_reg[23:16];
        ack_state = nack ? S_RETRY : S_WR_DEV;
      end
      S_WR_DEV: begin
        cmd_start = 1'b1; cmd_write = 1'b1; cmd_din = DEV_BYTE;
        ack_state = nack ? S_ABORT : S_WR_REG;
      end
      S_WR_REG: begin
        cmd_write = 1'b1; cmd_din = word_reg[15:8];
        ack_state = nack ? S_ABORT : S_WR_DAT;
      end
      S_WR_DAT: begin
        cmd_write = 1'b1; cmd_stop = 1'b1; cmd_din = word_reg[7:0];
        ack_state = nack ? S_RETRY : S_IDLE;
      end
      S_ABORT: begin
        cmd_stop  = 1'b1;
        ack_state = S_RETRY;
      end
      default: ack_state = state_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg      <= S_IDLE;
      word_reg       <= 24'h0;
      page_reg       <= 8'h00;
      page_valid_reg <= 1'b0;
      pending_reg    <= 1'b0;
      start_reg      <= 1'b0;
      stop_reg       <= 1'b0;
      write_reg      <= 1'b0;
      din_reg        <= 8'h00;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      retry_reg      <= 4'h0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.word_valid_i) begin
            word_reg  <= bus.word_i;
            retry_reg <= 4'h0;
            state_reg <= page_hit ? S_WR_DEV : S_PG_DEV;
          end
        end
        S_RETRY: begin
          page_valid_reg <= 1'b0;
          retry_reg      <= retry_inc;
          if (32'(retry_inc) > RETRY_MAX) begin
            state_reg <= S_ERROR;
            error_reg <= 1'b1;
          end else begin
            state_reg <= S_PG_DEV;
          end
        end
        S_ERROR: state_reg <= S_ERROR;
        S_PG_DEV, S_PG_REG, S_PG_DAT, S_WR_DEV, S_WR_REG, S_WR_DAT, S_ABORT: begin
          // Issue on the first cycle in the state; the clear on ack leaves
          // at least one quiet cycle before the next state's command.
          if (!pending_reg) begin
            start_reg   <= cmd_start;
            stop_reg    <= cmd_stop;
            write_reg   <= cmd_write;
            din_reg     <= cmd_din;
            pending_reg <= 1'b1;
          end else if (bus.cmd_ack_i) begin
            start_reg   <= 1'b0;
            stop_reg    <= 1'b0;
            write_reg   <= 1'b0;
            din_reg     <= 8'h00;
            pending_reg <= 1'b0;
            state_reg   <= ack_state;
            if (state_reg == S_PG_DAT && !nack) begin
              page_reg       <= word_reg[23:16];
              page_valid_reg <= 1'b1;
            end
            if (state_reg == S_WR_DAT && !nack) begin
              done_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.word_ready_o = (state_reg == S_IDLE);
  assign bus.busy_o       = (state_reg != S_IDLE) && (state_reg != S_ERROR);
  assign bus.start_o      = start_reg;
  assign bus.stop_o       = stop_reg;
  assign bus.write_o      = write_reg;
  assign bus.read_o       = 1'b0;
  assign bus.ack_in_o     = 1'b0;
  assign bus.din_o        = din_reg;
  assign bus.word_done_o  = done_reg;
  assign bus.error_o      = error_reg;
  assign bus.retry_cnt_o  = retry_reg;
endmodule
